sort_array_seq: RTL



---
 rtl/sort_array_seq_pkg.sv | 18 +
 rtl/sort_array_seq_if.sv | 34 +++
 rtl/sort_pair_mask.sv | 18 +
 rtl/sort_array_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sort_array_seq_pkg.sv
// Shared configuration and FSM state encoding for the odd-even sort row sequencer.
package sort_array_seq_pkg;

    localparam int unsigned OUTPUT_BUF_DATASIZE = 32;
    localparam int unsigned DefNPe              = 4;
    localparam int unsigned DefCmpLat           = 2;

    typedef enum logic [2:0] {
        StLoad,
        StWrite,
        StRecv,
        StCmp,
        StXfer,
        StSnap,
        StDrain
    } state_e;

endpackage

// File: rtl/sort_array_seq_if.sv
// Upstream stream, PE control/data bus and downstream stream of the sort sequencer.
interface sort_array_seq_if import sort_array_seq_pkg::*; #(
    parameter int unsigned N_PE   = DefNPe,
    parameter int unsigned DATA_W = OUTPUT_BUF_DATASIZE
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic                       write_enable;
    logic [N_PE*DATA_W-1:0]     write_data1;
    logic [N_PE*DATA_W-1:0]     write_data2;
    logic [N_PE-1:0]            sort_en;
    logic [N_PE-1:0]            receive_right;
    logic [N_PE-1:0]            send_right;
    logic [N_PE-1:0]            receive_left;
    logic [2*N_PE*DATA_W-1:0]   pe_out;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       busy;
    logic                       done;

    modport master (
        input  in_valid, in_data, pe_out, out_ready,
        output in_ready, write_enable, write_data1, write_data2, sort_en, receive_right,
               send_right, receive_left, out_valid, out_data, busy, done
    );

    modport slave (
        output in_valid, in_data, pe_out, out_ready,
        input  in_ready, write_enable, write_data1, write_data2, sort_en, receive_right,
               send_right, receive_left, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/sort_pair_mask.sv
// Left-member mask of the active odd-even pairs and the matching right-neighbour mask.
module sort_pair_mask #(
    parameter int unsigned N_PE = 4
) (
    input  logic            odd_i,
    output logic [N_PE-1:0] l_mask_o,
    output logic [N_PE-1:0] rl_mask_o
);
    // Even rounds pair (0,1),(2,3)...; odd rounds pair (1,2),(3,4)... and leave the ends idle.
    always_comb begin
        l_mask_o = '0;
        for (int unsigned i = 0; i + 1 < N_PE; i++) begin
            l_mask_o[i] = (i[0] == odd_i);
        end
    end

    assign rl_mask_o = {l_mask_o[N_PE-2:0], 1'b0};
endmodule

// File: rtl/sort_array_seq.sv
// Loads 2*N_PE words into the sort row, sequences the odd-even rounds and drains the result.
module sort_array_seq import sort_array_seq_pkg::*; #(
    parameter int unsigned N_PE    = DefNPe,
    parameter int unsigned DATA_W  = OUTPUT_BUF_DATASIZE,
    parameter int unsigned CMP_LAT = DefCmpLat,
    parameter int unsigned ROUNDS  = N_PE + 1
) (
    input logic              clk_i,
    input logic              rst_i,
    sort_array_seq_if.master bus
);
    localparam int unsigned NWords = 2 * N_PE;
    localparam int unsigned WcW    = $clog2(NWords + 1);
    localparam int unsigned RcW    = $clog2(ROUNDS + 1);
    localparam int unsigned CcW    = $clog2(CMP_LAT + 2);
    localparam logic [WcW-1:0] LastWord  = WcW'(NWords - 1);
    localparam logic [RcW-1:0] LastRound = RcW'(ROUNDS - 1);
    localparam logic [CcW-1:0] LastCmp   = CcW'(CMP_LAT);

    state_e                   state_q, state_d;
    logic [WcW-1:0]           word_q, word_d;
    logic [RcW-1:0]           round_q, round_d;
    logic [CcW-1:0]           cmp_q, cmp_d;
    logic [N_PE*DATA_W-1:0]   wd1_q, wd1_d, wd2_q, wd2_d;
    logic [2*N_PE*DATA_W-1:0] snap_q, snap_d;
    logic [N_PE-1:0]          l_mask, rl_mask;

    logic                     in_ready_q, in_ready_d, write_enable_q, write_enable_d;
    logic                     out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
    logic [N_PE-1:0]          sort_en_q, sort_en_d, recv_r_q, recv_r_d;
    logic [N_PE-1:0]          send_r_q, send_r_d, recv_l_q, recv_l_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;

    // Mask follows the next round so the registered strobes line up with the next state.
    sort_pair_mask #(
        .N_PE (N_PE)
    ) u_pair_mask (
        .odd_i     (round_d[0]),
        .l_mask_o  (l_mask),
        .rl_mask_o (rl_mask)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        round_d = round_q;
        cmp_d   = cmp_q;
        wd1_d   = wd1_q;
        wd2_d   = wd2_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        unique case (state_q)
            StLoad: if (bus.in_valid) begin
                if (word_q[0]) wd2_d[word_q[WcW-1:1]*DATA_W +: DATA_W] = bus.in_data;
                else           wd1_d[word_q[WcW-1:1]*DATA_W +: DATA_W] = bus.in_data;
                if (word_q == LastWord) begin
                    word_d  = '0;
                    state_d = StWrite;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            StWrite: begin
                round_d = '0;
                state_d = StRecv;
            end
            StRecv: begin
                cmp_d   = '0;
                state_d = StCmp;
            end
            StCmp: begin
                if (cmp_q == LastCmp) state_d = StXfer;
                else                  cmp_d   = cmp_q + 1'b1;
            end
            StXfer: begin
                round_d = round_q + 1'b1;
                state_d = (round_q == LastRound) ? StSnap : StRecv;
            end
            StSnap: begin
                snap_d  = bus.pe_out;
                state_d = StDrain;
            end
            StDrain: if (bus.out_ready) begin
                if (word_q == LastWord) begin
                    word_d  = '0;
                    done_d  = 1'b1;
                    state_d = StLoad;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        in_ready_d     = (state_d == StLoad);
        write_enable_d = (state_d == StWrite);
        busy_d         = !((state_d == StLoad) && (word_d == '0));
        recv_r_d       = (state_d == StRecv || state_d == StCmp) ? l_mask : '0;
        sort_en_d      = (state_d == StCmp && cmp_d == '0) ? l_mask : '0;
        send_r_d       = (state_d == StXfer) ? l_mask : '0;
        recv_l_d       = (state_d == StXfer) ? rl_mask : '0;
        out_valid_d    = (state_d == StDrain);
        out_data_d     = (state_d == StDrain) ? snap_d[word_d*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StLoad;
            word_q         <= '0;
            round_q        <= '0;
            cmp_q          <= '0;
            wd1_q          <= '0;
            wd2_q          <= '0;
            snap_q         <= '0;
            in_ready_q     <= 1'b1;
            write_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            recv_r_q       <= '0;
            sort_en_q      <= '0;
            send_r_q       <= '0;
            recv_l_q       <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            round_q        <= round_d;
            cmp_q          <= cmp_d;
            wd1_q          <= wd1_d;
            wd2_q          <= wd2_d;
            snap_q         <= snap_d;
            in_ready_q     <= in_ready_d;
            write_enable_q <= write_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            recv_r_q       <= recv_r_d;
            sort_en_q      <= sort_en_d;
            send_r_q       <= send_r_d;
            recv_l_q       <= recv_l_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.write_enable  = write_enable_q;
    assign bus.write_data1   = wd1_q;
    assign bus.write_data2   = wd2_q;
    assign bus.sort_en       = sort_en_q;
    assign bus.receive_right = recv_r_q;
    assign bus.send_right    = send_r_q;
    assign bus.receive_left  = recv_l_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule
